fft_sequencer: RTL and testbench

Control sequencer for the in-place radix-2 DIT FFT sample buffer.
- Loads N = 2^LOG2N samples from the input stream into the buffer at bit-reversed addresses.
- Runs LOG2N butterfly stages, one butterfly in flight at a time.
- Streams the N results out in natural order.
- Drives only addresses, write strobes and handshakes. The sample buffer and butterfly unit hold all data.

---
 rtl/fft_sequencer.sv | 170 +++++++++++++++++
 tb/tb_fft_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT buffer: bit-reversed load,
// LOG2N butterfly stages with one butterfly in flight, natural-order unload.
module fft_sequencer #(
  parameter int LOG2N = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic                                    ld_we,
  output logic [LOG2N-1:0]                        ld_addr,
  output logic                                    bf_go,
  output logic [LOG2N-1:0]                        bf_addr_a,
  output logic [LOG2N-1:0]                        bf_addr_b,
  output logic [LOG2N-2:0]                        bf_tw_idx,
  input  logic                                    bf_done,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [LOG2N-1:0]                        out_addr,
  output logic [((LOG2N > 2) ? $clog2(LOG2N) : 1)-1:0] stage,
  output logic                                    busy,
  output logic                                    done
);

  localparam int N  = 1 << LOG2N;
  localparam int SW = (LOG2N > 2) ? $clog2(LOG2N) : 1;
  localparam logic [LOG2N-1:0] ONE       = LOG2N'(1);
  localparam logic [LOG2N-1:0] LAST      = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] HALF_LAST = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] S_LAST    = LOG2N'(LOG2N - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, UNLOAD} state_t;

  state_t           state, state_nxt;
  logic [LOG2N-1:0] k, k_nxt, s, s_nxt, b, b_nxt, j, j_nxt;
  logic [LOG2N-1:0] addr_a_p0, addr_b_p0;
  logic [LOG2N-2:0] tw_p0;
  logic             in_compute;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [LOG2N-1:0] pos_of(input logic [LOG2N-1:0] s_i,
                                               input logic [LOG2N-1:0] b_i);
    return b_i & ((ONE << s_i) - ONE);
  endfunction

  // Upper operand: group index spread to a stride of 2*span, plus position in group.
  function automatic logic [LOG2N-1:0] calc_a(input logic [LOG2N-1:0] s_i,
                                               input logic [LOG2N-1:0] b_i);
    return ((b_i >> s_i) << (s_i + ONE)) | pos_of(s_i, b_i);
  endfunction

  function automatic logic [LOG2N-2:0] calc_tw(input logic [LOG2N-1:0] s_i,
                                                input logic [LOG2N-1:0] b_i);
    logic [LOG2N-1:0] t;
    t = pos_of(s_i, b_i) << (S_LAST - s_i);
    return t[LOG2N-2:0];
  endfunction

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    s_nxt     = s;
    b_nxt     = b;
    j_nxt     = j;
    in_ready  = 1'b0;
    ld_we     = 1'b0;
    ld_addr   = '0;
    bf_go     = 1'b0;
    out_valid = 1'b0;
    out_addr  = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          k_nxt     = '0;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ld_we   = 1'b1;
          ld_addr = bitrev(k);
          if (k == LAST) begin
            state_nxt = ISSUE;
            k_nxt     = '0;
            s_nxt     = '0;
            b_nxt     = '0;
          end else begin
            k_nxt = k + ONE;
          end
        end
      end
      ISSUE: begin
        bf_go     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bf_done) begin
          if (b != HALF_LAST) begin
            b_nxt     = b + ONE;
            state_nxt = ISSUE;
          end else if (s != S_LAST) begin
            b_nxt     = '0;
            s_nxt     = s + ONE;
            state_nxt = ISSUE;
          end else begin
            b_nxt     = '0;
            s_nxt     = '0;
            j_nxt     = '0;
            state_nxt = UNLOAD;
          end
        end
      end
      UNLOAD: begin
        out_valid = 1'b1;
        out_addr  = j;
        if (out_ready) begin
          if (j == LAST) begin
            done      = 1'b1;
            j_nxt     = '0;
            state_nxt = IDLE;
          end else begin
            j_nxt = j + ONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      s     <= '0;
      b     <= '0;
      j     <= '0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      s     <= s_nxt;
      b     <= b_nxt;
      j     <= j_nxt;
    end
  end

  // Stage p0: operand addresses latched on entry to ISSUE, held through WAIT.
  always_ff @(posedge clk) begin
    if (state_nxt == ISSUE) begin
      addr_a_p0 <= calc_a(s_nxt, b_nxt);
      addr_b_p0 <= calc_a(s_nxt, b_nxt) + (ONE << s_nxt);
      tw_p0     <= calc_tw(s_nxt, b_nxt);
    end
  end

  assign in_compute = (state == ISSUE) || (state == WAIT);
  assign bf_addr_a  = in_compute ? addr_a_p0 : '0;
  assign bf_addr_b  = in_compute ? addr_b_p0 : '0;
  assign bf_tw_idx  = in_compute ? tw_p0 : '0;
  assign stage      = in_compute ? s[SW-1:0] : '0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_sequencer.sv
// Scoreboard bench for fft_sequencer: expected load/butterfly/unload streams
// are queued per frame from FFT loop rules and popped by a negedge monitor.
module tb_fft_sequencer;
  localparam int LOG2N = 4;
  localparam int N     = 1 << LOG2N;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready, bf_done_r, bf_done_x;
  logic bf_done_w;
  logic in_ready, ld_we, bf_go, out_valid, busy, done;
  logic [LOG2N-1:0] ld_addr, bf_addr_a, bf_addr_b, out_addr;
  logic [LOG2N-2:0] bf_tw_idx;
  logic [SW-1:0]    stage;

  assign bf_done_w = bf_done_r | bf_done_x;

  fft_sequencer #(.LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_go(bf_go), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw_idx(bf_tw_idx), .bf_done(bf_done_w), .out_valid(out_valid),
    .out_ready(out_ready), .out_addr(out_addr), .stage(stage),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int a; int b; int tw; int s; } bf_t;
  bf_t bf_q[$];
  int  ld_q[$];
  int  out_q[$];
  bf_t cur;
  bit  waiting = 1'b0;
  int  done_cnt = 0;
  int  total = 0;
  int  bad = 0;
  int  max_dly = 0;
  bit  spur_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int outs_sum();
    return int'(in_ready) + int'(ld_we) + int'(ld_addr) + int'(bf_go) +
           int'(bf_addr_a) + int'(bf_addr_b) + int'(bf_tw_idx) + int'(out_valid) +
           int'(out_addr) + int'(stage) + int'(busy) + int'(done);
  endfunction

  // Reference: bit-reversed load order, classic group/position butterfly loops.
  task automatic push_frame();
    bf_t e;
    for (int k = 0; k < N; k++) begin
      int r, x;
      r = 0;
      x = k;
      for (int i = 0; i < LOG2N; i++) begin
        r = r * 2 + x % 2;
        x = x / 2;
      end
      ld_q.push_back(r);
    end
    for (int s = 0; s < LOG2N; s++) begin
      int span;
      span = 1 << s;
      for (int g = 0; g < N / (2 * span); g++)
        for (int p = 0; p < span; p++) begin
          e.a  = g * 2 * span + p;
          e.b  = e.a + span;
          e.tw = p * (N / (2 * span));
          e.s  = s;
          bf_q.push_back(e);
        end
    end
    for (int j = 0; j < N; j++) out_q.push_back(j);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transaction.
  always @(negedge clk) begin
    int e;
    if (in_ready) chk("ld_we_vs_valid", ld_we, in_valid);
    if (ld_we) begin
      if (ld_q.size() == 0) chk("ld_extra", int'(ld_addr) + 100, 100 + N);
      else chk("ld_addr", ld_addr, ld_q.pop_front());
    end
    if (bf_go) begin
      chk("bf_go_while_waiting", waiting, 0);
      if (bf_q.size() == 0) chk("bf_extra", bf_q.size() + 1, 0);
      else begin
        cur = bf_q.pop_front();
        chk("bf_addr_a", bf_addr_a, cur.a);
        chk("bf_addr_b", bf_addr_b, cur.b);
        chk("bf_tw_idx", bf_tw_idx, cur.tw);
        chk("stage", stage, cur.s);
        waiting = 1'b1;
      end
    end else if (waiting) begin
      chk("bf_hold", bf_addr_a * 65536 + bf_addr_b * 256 + bf_tw_idx,
          cur.a * 65536 + cur.b * 256 + cur.tw);
      if (bf_done_w) waiting = 1'b0;
    end
    if (out_valid) begin
      if (out_q.size() == 0) chk("out_extra", out_q.size() + 1, 0);
      else if (out_ready) begin
        e = out_q.pop_front();
        chk("out_addr", out_addr, e);
        chk("done_flag", done, int'(e == N - 1));
        if (done) done_cnt++;
      end else begin
        chk("out_hold", out_addr, out_q[0]);
        chk("done_stall", done, 0);
      end
    end else begin
      chk("done_stray", done, 0);
    end
  end

  // Butterfly unit model: random latency, optional spurious done during ISSUE.
  initial begin
    int dly;
    bf_done_r = 1'b0;
    forever begin
      @(posedge clk); #1;
      bf_done_r = 1'b0;
      if (bf_go) begin
        if (spur_en && $urandom_range(0, 1) == 1) bf_done_r = 1'b1;
        dly = $urandom_range(0, max_dly);
        repeat (dly + 1) begin
          @(posedge clk); #1;
          bf_done_r = 1'b0;
        end
        bf_done_r = 1'b1;
      end
    end
  end

  function automatic logic ready_pat(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx % 3 == 0);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode 0: no stalls; 1: toggled ready + slow/spurious done; 2: random;
  // 3: reset during stage-2 WAIT; 4: start pulses during LOAD/UNLOAD with gaps.
  task automatic run_frame(input int mode);
    int cnt, guard, idx, t0;
    bit finished;
    max_dly  = (mode == 0) ? 0 : (mode == 1) ? 5 : 3;
    spur_en  = (mode == 1 || mode == 2);
    done_cnt = 0;
    push_frame();
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0;
    guard = 0;
    while (cnt < N && guard < 400) begin
      in_valid = (mode <= 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      start    = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) cnt++;
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_count", cnt, N);
    idx = 0;
    out_ready = ready_pat(mode, 0);
    @(negedge clk);
    chk("in_ready_after_load", in_ready, 0);
    if (mode == 3) begin
      guard = 0;
      while (!(busy && stage == 2 && !bf_go) && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      chk("reach_s2_wait", stage, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      waiting = 1'b0;
      ld_q.delete();
      bf_q.delete();
      out_q.delete();
      @(negedge clk);
      chk("outs_after_rst", outs_sum(), 0);
      @(posedge clk); #1;
      bf_done_x = 1'b1;
      @(posedge clk); #1;
      bf_done_x = 1'b0;
      repeat (8) begin
        @(negedge clk);
        chk("idle_after_rst", int'(busy) + int'(bf_go), 0);
      end
      return;
    end
    guard = 0;
    while (!out_valid && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("compute_finished", out_valid, 1);
    finished = 1'b0;
    guard = 0;
    while (!finished && guard < 400) begin
      if (out_valid && out_ready && done) finished = 1'b1;
      else begin
        @(posedge clk); #1;
        idx++;
        out_ready = ready_pat(mode, idx);
        start     = (mode == 4);
        @(negedge clk);
        guard++;
      end
    end
    chk("unload_finished", finished, 1);
    if (mode == 0) chk("frame_latency", cyc - t0 + 1, 1 + N + LOG2N * N + N);
    @(posedge clk); #1;
    start     = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_count", done_cnt, 1);
    chk("queues_drained", ld_q.size() + bf_q.size() + out_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bf_done_x = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs_sum(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);
    run_frame(0);
    run_frame(4);
    run_frame(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not complete");
  end

endmodule
